// File: rtl/bram_read_arbiter_pkg.sv
// rtl/bram_read_arbiter_pkg.sv - shared types and helpers for the BRAM read arbiter
package bram_read_arbiter_pkg;

    localparam int MAX_CLIENTS  = 8;
    localparam int CLIENT_IDX_W = 3;

    typedef logic [CLIENT_IDX_W-1:0] client_idx_t;
    typedef logic [MAX_CLIENTS-1:0]  client_mask_t;

    function automatic client_mask_t idx_to_onehot(input client_idx_t idx);
        return client_mask_t'(1) << idx;
    endfunction

    function automatic client_idx_t onehot_to_idx(input client_mask_t oh);
        client_idx_t v_idx;
        v_idx = '0;
        for (int i = 0; i < MAX_CLIENTS; i++) begin
            if (oh[i]) begin
                v_idx = client_idx_t'(i);
            end
        end
        return v_idx;
    endfunction

endpackage

// File: rtl/bram_arb_tag_fifo.sv
// rtl/bram_arb_tag_fifo.sv - small synchronous FIFO holding client tags of outstanding reads
module bram_arb_tag_fifo #(
    parameter int depth = 2,
    parameter int width = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enq,
    input  logic             deq,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout,
    output logic             full_n,
    output logic             empty_n
);

    localparam int PTR_W = (depth > 1) ? $clog2(depth) : 1;
    localparam int CNT_W = $clog2(depth + 1);

    logic [width-1:0] r_mem [depth];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_enq;
    logic w_do_deq;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full_n   = (r_count != CNT_W'(depth));
    assign empty_n  = (r_count != '0);
    assign w_do_enq = enq & full_n;
    assign w_do_deq = deq & empty_n;
    assign dout     = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < depth; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_enq) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_do_deq) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_enq, w_do_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bram_read_arbiter.sv
// rtl/bram_read_arbiter.sv - round-robin sharing of one BRAM read port with in-order tagged responses
module bram_read_arbiter
    import bram_read_arbiter_pkg::*;
#(
    parameter int n_clients    = 4,
    parameter int addr_width   = 10,
    parameter int data_width   = 32,
    parameter int max_inflight = 2,
    parameter int tag_width    = 3
) (
    input  logic                            CLK,
    input  logic                            RST_N,
    input  logic [n_clients*addr_width-1:0] REQ_ADDR,
    input  logic [n_clients-1:0]            REQ_VALID,
    output logic [n_clients-1:0]            REQ_GRANT,
    output logic [data_width-1:0]           RSP_DATA,
    output logic [n_clients-1:0]            RSP_VALID,
    input  logic [n_clients-1:0]            RSP_DEQ,
    output logic [addr_width-1:0]           BRAM_RD_ADDR,
    output logic                            BRAM_RD_EN,
    input  logic                            BRAM_RD_RDY,
    input  logic [data_width-1:0]           BRAM_DOUT,
    input  logic                            BRAM_DOUT_RDY,
    output logic                            BRAM_DOUT_EN
);

    localparam int CREDIT_W = $clog2(max_inflight + 1);

    logic [CREDIT_W-1:0]  r_credit;
    logic [tag_width-1:0] r_rr_ptr;

    logic [tag_width-1:0] w_winner;
    logic [tag_width-1:0] w_rr_next;
    logic [tag_width-1:0] w_head;
    logic                 w_found;
    logic                 w_can_issue;
    logic                 w_fifo_full_n;
    logic                 w_fifo_empty_n;
    logic                 w_dout_en;
    logic [n_clients-1:0] w_grant;
    logic [n_clients-1:0] w_rsp_valid;
    int                   v_idx;

    // First requester at or after the pointer, wrapping around the client ring.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        v_idx    = 0;
        for (int k = 0; k < n_clients; k++) begin
            v_idx = (int'(r_rr_ptr) + k) % n_clients;
            if (!w_found && REQ_VALID[v_idx]) begin
                w_found  = 1'b1;
                w_winner = tag_width'(v_idx);
            end
        end
    end

    // Issue decisions use registered credit and FIFO state only, so a same-cycle dequeue never frees a slot early.
    assign w_can_issue = RST_N & (r_credit != '0) & BRAM_RD_RDY & w_fifo_full_n & (|REQ_VALID);

    assign w_grant     = w_can_issue ? n_clients'(idx_to_onehot(client_idx_t'(w_winner))) : '0;
    assign w_rsp_valid = (BRAM_DOUT_RDY & w_fifo_empty_n)
                         ? n_clients'(idx_to_onehot(client_idx_t'(w_head))) : '0;
    assign w_dout_en   = |(RSP_DEQ & w_rsp_valid);
    assign w_rr_next   = (int'(w_winner) == n_clients - 1) ? '0 : w_winner + 1'b1;

    assign REQ_GRANT    = w_grant;
    assign BRAM_RD_EN   = w_can_issue;
    assign BRAM_RD_ADDR = REQ_ADDR[int'(w_winner)*addr_width +: addr_width];
    assign RSP_DATA     = BRAM_DOUT;
    assign RSP_VALID    = w_rsp_valid;
    assign BRAM_DOUT_EN = w_dout_en;

    bram_arb_tag_fifo #(
        .depth (max_inflight),
        .width (tag_width)
    ) u_tag_fifo (
        .clk     (CLK),
        .rst_n   (RST_N),
        .enq     (w_can_issue),
        .deq     (w_dout_en),
        .din     (w_winner),
        .dout    (w_head),
        .full_n  (w_fifo_full_n),
        .empty_n (w_fifo_empty_n)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rr_ptr <= '0;
        end else if (w_can_issue) begin
            r_rr_ptr <= w_rr_next;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_credit <= CREDIT_W'(max_inflight);
        end else begin
            case ({w_can_issue, w_dout_en})
                2'b10:   r_credit <= r_credit - 1'b1;
                2'b01:   r_credit <= r_credit + 1'b1;
                default: r_credit <= r_credit;
            endcase
        end
    end

    always @(posedge CLK) begin
        if (RST_N) begin
            assert (!(w_can_issue && !w_dout_en && r_credit == '0))
                else $error("bram_read_arbiter: credit underflow");
            assert (!(w_dout_en && !w_can_issue && r_credit == CREDIT_W'(max_inflight)))
                else $error("bram_read_arbiter: credit overflow");
            assert (!(BRAM_DOUT_RDY && !w_fifo_empty_n))
                else $error("bram_read_arbiter: BRAM data with no outstanding tag");
        end
    end

endmodule

// File: tb/tb_bram_read_arbiter.sv
// tb/tb_bram_read_arbiter.sv - self-checking bench for bram_read_arbiter with a behavioural BRAM and reference model
module tb_bram_read_arbiter;

    localparam int NC = 4;
    localparam int AW = 10;
    localparam int DW = 32;

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic [NC*AW-1:0] REQ_ADDR;
    logic [NC-1:0]   REQ_VALID;
    logic [NC-1:0]   REQ_GRANT;
    logic [DW-1:0]   RSP_DATA;
    logic [NC-1:0]   RSP_VALID;
    logic [NC-1:0]   RSP_DEQ;
    logic [AW-1:0]   BRAM_RD_ADDR;
    logic            BRAM_RD_EN;
    logic            BRAM_RD_RDY;
    logic [DW-1:0]   BRAM_DOUT;
    logic            BRAM_DOUT_RDY;
    logic            BRAM_DOUT_EN;

    logic [NC-1:0]   req_valid = '0;
    logic [NC-1:0]   rsp_deq = '0;
    logic            rd_rdy = 1'b1;
    logic [AW-1:0]   addr [NC];

    assign REQ_ADDR    = {addr[3], addr[2], addr[1], addr[0]};
    assign REQ_VALID   = req_valid;
    assign RSP_DEQ     = rsp_deq;
    assign BRAM_RD_RDY = rd_rdy;

    always #5 CLK = ~CLK;

    bram_read_arbiter dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .REQ_ADDR      (REQ_ADDR),
        .REQ_VALID     (REQ_VALID),
        .REQ_GRANT     (REQ_GRANT),
        .RSP_DATA      (RSP_DATA),
        .RSP_VALID     (RSP_VALID),
        .RSP_DEQ       (RSP_DEQ),
        .BRAM_RD_ADDR  (BRAM_RD_ADDR),
        .BRAM_RD_EN    (BRAM_RD_EN),
        .BRAM_RD_RDY   (BRAM_RD_RDY),
        .BRAM_DOUT     (BRAM_DOUT),
        .BRAM_DOUT_RDY (BRAM_DOUT_RDY),
        .BRAM_DOUT_EN  (BRAM_DOUT_EN)
    );

    // BRAM: one-cycle read stage feeding a 2-entry output buffer.
    logic [DW-1:0] mem [1024];
    logic          st_v;
    logic [DW-1:0] st_d;
    logic [1:0]    bcnt;
    logic [DW-1:0] b0, b1;

    assign BRAM_DOUT_RDY = (bcnt != 2'd0);
    assign BRAM_DOUT     = b0;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            st_v <= 1'b0; st_d <= '0; bcnt <= 2'd0; b0 <= '0; b1 <= '0;
        end else begin
            st_v <= BRAM_RD_EN;
            st_d <= mem[BRAM_RD_ADDR];
            case ({st_v, BRAM_DOUT_EN})
                2'b01: begin b0 <= b1; bcnt <= bcnt - 2'd1; end
                2'b10: begin
                    if (bcnt == 2'd0) b0 <= st_d; else b1 <= st_d;
                    bcnt <= bcnt + 2'd1;
                end
                2'b11: begin
                    if (bcnt == 2'd1) b0 <= st_d;
                    else begin b0 <= b1; b1 <= st_d; end
                end
                default: ;
            endcase
        end
    end

    typedef struct { int client; logic [DW-1:0] data; } rsp_t;
    rsp_t m_q[$];
    rsp_t rx_q[$];
    int   m_rr;
    int   n_tests = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model, then advance the model across the edge.
    task automatic cycle(output int gidx);
        logic [NC-1:0] eg, ev;
        logic          eden;
        int            w, c;
        #1;
        eg = '0; ev = '0; eden = 1'b0; w = -1;
        if (rd_rdy && m_q.size() < 2 && req_valid != '0) begin
            for (int k = 0; k < NC; k++) begin
                c = (m_rr + k) % NC;
                if (w < 0 && req_valid[c]) w = c;
            end
            eg = NC'(1 << w);
        end
        if (BRAM_DOUT_RDY && m_q.size() > 0) begin
            ev   = NC'(1 << m_q[0].client);
            eden = rsp_deq[m_q[0].client];
        end
        chk("grant", REQ_GRANT, eg);
        chk("rd_en", BRAM_RD_EN, eg != '0);
        if (w >= 0) chk("rd_addr", BRAM_RD_ADDR, addr[w]);
        chk("rsp_valid", RSP_VALID, ev);
        if (ev != '0) chk("rsp_data", RSP_DATA, m_q[0].data);
        chk("dout_en", BRAM_DOUT_EN, eden);
        if (eden) rx_q.push_back('{m_q[0].client, RSP_DATA});
        gidx = -1;
        for (int k = 0; k < NC; k++) if (REQ_GRANT[k]) gidx = k;
        @(posedge CLK);
        if (eden) void'(m_q.pop_front());
        if (w >= 0) begin
            m_q.push_back('{w, mem[addr[w]]});
            m_rr = (w + 1) % NC;
        end
        @(negedge CLK);
    endtask

    task automatic reset_outputs_zero(input string tag);
        chk({tag, "_grant"}, REQ_GRANT, 0);
        chk({tag, "_rd_en"}, BRAM_RD_EN, 0);
        chk({tag, "_rsp_valid"}, RSP_VALID, 0);
        chk({tag, "_dout_en"}, BRAM_DOUT_EN, 0);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        m_q.delete();
        m_rr = 0;
    endtask

    task automatic drain();
        int g;
        req_valid = '0;
        rsp_deq   = '1;
        for (int i = 0; i < 12; i++) cycle(g);
        chk("drain_empty", m_q.size(), 0);
    endtask

    task automatic count_grants(input int ncyc, output int ng);
        int g;
        ng = 0;
        for (int i = 0; i < ncyc; i++) begin
            cycle(g);
            if (g >= 0) ng++;
        end
    endtask

    initial begin
        int g, ng, got;
        int gq[$];
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[5] = 32'hA5;
        mem[9] = 32'hB9;
        for (int i = 0; i < NC; i++) addr[i] = '0;
        m_rr = 0;

        // Reset state with every client requesting.
        req_valid = '1; rd_rdy = 1'b1;
        #3;
        reset_outputs_zero("reset");
        @(negedge CLK);
        do_reset();

        // Client 2 reads addresses 5 then 9.
        req_valid = 4'b0100; rsp_deq = '1; addr[2] = 10'd5; got = 0; rx_q.delete();
        for (int i = 0; i < 10 && got < 2; i++) begin
            cycle(g);
            if (g == 2) begin
                got++;
                if (got == 1) addr[2] = 10'd9;
                else req_valid = '0;
            end
        end
        chk("t1_grants", got, 2);
        drain();
        chk("t1_rx_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            chk("t1_rx0_client", rx_q[0].client, 2);
            chk("t1_rx0_data", rx_q[0].data, 32'hA5);
            chk("t1_rx1_client", rx_q[1].client, 2);
            chk("t1_rx1_data", rx_q[1].data, 32'hB9);
        end

        // All clients streaming: grants rotate 0,1,2,3,...
        do_reset();
        req_valid = '1; rsp_deq = '1; gq.delete();
        for (int i = 0; i < 24; i++) begin
            for (int k = 0; k < NC; k++) addr[k] = AW'($urandom);
            cycle(g);
            if (g >= 0) gq.push_back(g);
        end
        chk("t2_grant_count", gq.size() >= 8, 1);
        for (int i = 0; i < 8 && i < gq.size(); i++) chk("t2_rr_order", gq[i], i % NC);
        drain();

        // Held dequeue: two grants, then exactly one after a single dequeue.
        req_valid = '1; rsp_deq = '0;
        count_grants(8, ng);
        chk("t3_stalled_grants", ng, 2);
        rsp_deq = '1;
        count_grants(1, got);
        rsp_deq = '0;
        count_grants(6, ng);
        chk("t3_grant_after_deq", ng + got, 1);
        drain();

        // Pointer at 2 with clients 1 and 3 requesting.
        do_reset();
        req_valid = 4'b0010; rsp_deq = '1;
        cycle(g);
        chk("t4_setup_grant", g, 1);
        req_valid = 4'b1010; gq.delete();
        for (int i = 0; i < 10 && gq.size() < 2; i++) begin
            cycle(g);
            if (g >= 0) begin
                gq.push_back(g);
                req_valid[g] = 1'b0;
            end
        end
        chk("t4_count", gq.size(), 2);
        if (gq.size() == 2) begin
            chk("t4_first", gq[0], 3);
            chk("t4_second", gq[1], 1);
        end
        req_valid = 4'b1100;
        cycle(g);
        chk("t4_ptr_at_2", g, 2);
        drain();

        // BRAM not ready: no grants, credit untouched.
        rd_rdy = 1'b0; req_valid = '1; rsp_deq = '1;
        count_grants(4, ng);
        chk("t5_no_grant", ng, 0);
        rd_rdy = 1'b1; rsp_deq = '0;
        count_grants(6, ng);
        chk("t5_credit_kept", ng, 2);
        drain();

        // Reset while two reads are outstanding.
        req_valid = '1; rsp_deq = '0;
        count_grants(4, ng);
        chk("t6_outstanding", ng, 2);
        #3 RST_N = 1'b0;
        #1 reset_outputs_zero("t6_async");
        @(negedge CLK);
        RST_N = 1'b1; m_q.delete(); m_rr = 0; rx_q.delete();
        req_valid = 4'b0001; rsp_deq = '1; addr[0] = AW'($urandom); got = 0;
        for (int i = 0; i < 5 && got == 0; i++) begin
            cycle(g);
            if (g == 0) begin got = 1; req_valid = '0; end
        end
        chk("t6_fresh_grant", got, 1);
        drain();
        chk("t6_fresh_rx", rx_q.size(), 1);
        if (rx_q.size() == 1) chk("t6_fresh_data", rx_q[0].data, mem[addr[0]]);
        req_valid = '1; rsp_deq = '0;
        count_grants(6, ng);
        chk("t6_credit_restored", ng, 2);
        drain();

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            req_valid = NC'($urandom);
            rsp_deq   = NC'($urandom);
            rd_rdy    = ($urandom_range(0, 7) != 0);
            for (int k = 0; k < NC; k++) addr[k] = AW'($urandom);
            cycle(g);
        end
        rd_rdy = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
